// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing sets (640x480@60 and a tiny test mode) and a sync-window helper
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int TEST_H_ACTIVE = 4;
  localparam int TEST_H_FP = 1;
  localparam int TEST_H_SYNC = 2;
  localparam int TEST_H_BP = 1;
  localparam int TEST_V_ACTIVE = 3;
  localparam int TEST_V_FP = 1;
  localparam int TEST_V_SYNC = 1;
  localparam int TEST_V_BP = 1;
  function automatic logic in_window(int p, int lo, int len);
    return p >= lo && p < lo + len;
  endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: Clock divider, oTick pulses every CLK_DIV enabled Clocks (ports Clock, Reset, Enable, oTick)
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic oTick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  assign oTick = Enable && div == DMAX;
  always_ff @(posedge Clock)
    if (Reset) div <= '0;
    else if (Enable) div <= div == DMAX ? '0 : div + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; stage 1 gives oX/oY/oActive/oLineStart/oFrameStart, stage 2 gives oHsync/oVsync/RGB one pixel later
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CLK_DIV = 2,
  parameter int CW = 11
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  input  logic [2:0]    iColor,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oActive,
  output logic          oLineStart,
  output logic          oFrameStart,
  output logic          oHsync,
  output logic          oVsync,
  output logic          oRed,
  output logic          oGreen,
  output logic          oBlue
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HM = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VM = CW'(V_TOTAL - 1);
  logic tick;
  logic [CW-1:0] h, v;
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clock(Clock),
    .Reset(Reset),
    .Enable(Enable),
    .oTick(tick)
  );
  always_ff @(posedge Clock)
    if (Reset) begin
      h <= '0;
      v <= '0;
      oX <= '0;
      oY <= '0;
      oActive <= 1'b0;
      oLineStart <= 1'b0;
      oFrameStart <= 1'b0;
      oHsync <= ~HS_POL;
      oVsync <= ~VS_POL;
      {oRed, oGreen, oBlue} <= 3'b000;
    end else if (tick) begin
      h <= h == HM ? '0 : h + 1'b1;
      v <= h != HM ? v : v == VM ? '0 : v + 1'b1;
      oX <= h;
      oY <= v;
      oActive <= h < HA && v < VA;
      oLineStart <= h == '0;
      oFrameStart <= h == '0 && v == '0;
      oHsync <= in_window(int'(oX), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
      oVsync <= in_window(int'(oY), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
      {oRed, oGreen, oBlue} <= oActive ? iColor : 3'b000;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen in the 8x6 test mode (base, inverted polarity, CLK_DIV=2)
module tb_vga_timing_gen;
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic act, ls, fs, hs, vs;
    logic [2:0] rgb;
  } rec_t;
  logic Clock = 1'b0;
  logic Reset_a = 1'b1, Enable_a = 1'b1, Reset_b = 1'b1, Enable_b = 1'b1;
  logic rst_a_q = 1'b1, tk_a_q = 1'b0, rst_b_q = 1'b1, tk_b_q = 1'b0, exp_tk_b = 1'b0;
  int en_cnt = 0;
  int n_chk = 0, n_fail = 0;
  rec_t q[3][$];
  rec_t last[3];
  logic [10:0] x0, y0, x1, y1, x2, y2;
  logic a0, l0, f0, h0, v0, r0, g0, b0;
  logic a1, l1, f1, h1, v1, r1, g1, b1;
  logic a2, l2, f2, h2, v2, r2, g2, b2;
  rec_t o0, o1, o2;
  localparam logic [2:0] C0 = 3'b111, C1 = 3'b101, C2 = 3'b011;
  always #5 Clock = ~Clock;
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .CW(11)) d0 (
    .Clock(Clock), .Reset(Reset_a), .Enable(Enable_a), .iColor(C0), .oX(x0), .oY(y0), .oActive(a0),
    .oLineStart(l0), .oFrameStart(f0), .oHsync(h0), .oVsync(v0), .oRed(r0), .oGreen(g0), .oBlue(b0));
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(11)) d1 (
    .Clock(Clock), .Reset(Reset_a), .Enable(Enable_a), .iColor(C1), .oX(x1), .oY(y1), .oActive(a1),
    .oLineStart(l1), .oFrameStart(f1), .oHsync(h1), .oVsync(v1), .oRed(r1), .oGreen(g1), .oBlue(b1));
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .CW(11)) d2 (
    .Clock(Clock), .Reset(Reset_b), .Enable(Enable_b), .iColor(C2), .oX(x2), .oY(y2), .oActive(a2),
    .oLineStart(l2), .oFrameStart(f2), .oHsync(h2), .oVsync(v2), .oRed(r2), .oGreen(g2), .oBlue(b2));
  assign o0 = {x0, y0, a0, l0, f0, h0, v0, r0, g0, b0};
  assign o1 = {x1, y1, a1, l1, f1, h1, v1, r1, g1, b1};
  assign o2 = {x2, y2, a2, l2, f2, h2, v2, r2, g2, b2};
  function automatic rec_t reset_rec(bit hp, bit vp);
    rec_t r = '0;
    r.hs = ~hp;
    r.vs = ~vp;
    return r;
  endfunction
  // Expected outputs after the n-th tick since reset: 8 columns x 6 lines,
  // hsync on columns 5,6, vsync on line 4, stage 2 one pixel behind stage 1.
  function automatic rec_t exp_at(int n, bit hp, bit vp, logic [2:0] col);
    rec_t r;
    int p, x, y, px, py;
    p = n - 1;
    x = p % 8;
    y = (p / 8) % 6;
    r.x = 11'(x);
    r.y = 11'(y);
    r.act = x < 4 && y < 3;
    r.ls = x == 0;
    r.fs = x == 0 && y == 0;
    if (n == 1) begin
      r.hs = ~hp;
      r.vs = ~vp;
      r.rgb = 3'b000;
    end else begin
      px = (n - 2) % 8;
      py = ((n - 2) / 8) % 6;
      r.hs = (px == 5 || px == 6) ? hp : ~hp;
      r.vs = py == 4 ? vp : ~vp;
      r.rgb = (px < 4 && py < 3) ? col : 3'b000;
    end
    return r;
  endfunction
  task automatic check(string nm, rec_t act, rec_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b rgb=%b exp x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b rgb=%b",
        nm, $time, act.x, act.y, act.act, act.ls, act.fs, act.hs, act.vs, act.rgb,
        exp.x, exp.y, exp.act, exp.ls, exp.fs, exp.hs, exp.vs, exp.rgb);
    end
  endtask
  task automatic mon(int i, string nm, logic rq, logic tq, rec_t o, rec_t rr);
    if (rq) begin
      check({nm, "_reset"}, o, rr);
      last[i] = rr;
    end else if (tq) begin
      if (q[i].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_tick t=%0t got unexpected tick exp none queued", nm, $time);
      end else begin
        last[i] = q[i].pop_front();
        check({nm, "_tick"}, o, last[i]);
      end
    end else check({nm, "_hold"}, o, last[i]);
  endtask
  always @(posedge Clock) begin
    rst_a_q <= Reset_a;
    tk_a_q <= Enable_a && !Reset_a;
    rst_b_q <= Reset_b;
    tk_b_q <= exp_tk_b;
  end
  always @(negedge Clock) mon(0, "base", rst_a_q, tk_a_q, o0, reset_rec(1'b0, 1'b0));
  always @(negedge Clock) mon(1, "pol", rst_a_q, tk_a_q, o1, reset_rec(1'b1, 1'b1));
  always @(negedge Clock) mon(2, "div2", rst_b_q, tk_b_q, o2, reset_rec(1'b0, 1'b0));
  task automatic push_a(int n);
    for (int k = 1; k <= n; k++) begin
      q[0].push_back(exp_at(k, 1'b0, 1'b0, C0));
      q[1].push_back(exp_at(k, 1'b1, 1'b1, C1));
    end
  endtask
  task automatic step_a(logic r, logic e);
    Reset_a = r;
    Enable_a = e;
    @(posedge Clock);
    #1;
  endtask
  task automatic step_b(logic r, logic e);
    Reset_b = r;
    Enable_b = e;
    exp_tk_b = !r && e && en_cnt[0];
    if (r) en_cnt = 0;
    else if (e) en_cnt++;
    @(posedge Clock);
    #1;
  endtask
  task automatic run_a();
    repeat (2) step_a(1'b1, 1'b1);
    push_a(50);
    repeat (50) step_a(1'b0, 1'b1);
    repeat (3) step_a(1'b0, 1'b0);
    step_a(1'b1, 1'b1);
    push_a(22);
    repeat (22) step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    push_a(3);
    repeat (3) step_a(1'b0, 1'b1);
    repeat (2) step_a(1'b0, 1'b0);
  endtask
  task automatic run_b();
    repeat (2) step_b(1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) q[2].push_back(exp_at(k, 1'b0, 1'b0, C2));
    repeat (6) step_b(1'b0, 1'b1);
    repeat (5) step_b(1'b0, 1'b0);
    repeat (10) step_b(1'b0, 1'b1);
    repeat (2) step_b(1'b0, 1'b0);
  endtask
  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (2) @(posedge Clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (q[i].size() != 0) begin
        n_fail++;
        $display("FAIL drain%0d got %0d entries left exp 0", i, q[i].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
